// File: rtl/cci_mpf_shim_wro_pkg.sv
// Shared types and helpers for the write/read ordering shim.
// Widths of the flattened CCI request/response fields, the bucket hash,
// per-bucket outstanding-write counters and write tag bookkeeping.
package cci_mpf_shim_wro_pkg;

    localparam int ADDR_BITS  = 32;   // line address
    localparam int DATA_BITS  = 64;
    localparam int MDATA_BITS = 16;
    localparam int HASH_BITS  = 6;
    localparam int CTR_BITS   = 4;
    localparam int N_WR_TAGS  = 32;
    localparam int TAG_BITS   = $clog2(N_WR_TAGS);
    localparam int N_BUCKETS  = 2 ** HASH_BITS;

    typedef logic [ADDR_BITS-1:0]  t_wro_addr;
    typedef logic [DATA_BITS-1:0]  t_wro_data;
    typedef logic [MDATA_BITS-1:0] t_wro_mdata;
    typedef logic [HASH_BITS-1:0]  t_wro_hash;
    typedef logic [TAG_BITS-1:0]   t_wro_tag;
    typedef logic [CTR_BITS-1:0]   t_wro_ctr;

    // Per-tag state kept while a write is in flight: the mdata bits that the
    // tag overwrote, and the bucket to decrement when the response arrives.
    typedef struct packed {
        logic [TAG_BITS-1:0] orig_mdata;
        t_wro_hash           hash;
    } t_wro_tag_meta;

    localparam t_wro_ctr WRO_CTR_MAX = '1;

    // XOR-fold of the line address: address bit i lands on hash bit i mod HASH_BITS.
    function automatic t_wro_hash wro_hash(input t_wro_addr addr);
        t_wro_hash h;
        h = '0;
        for (int i = 0; i < ADDR_BITS; i++) begin
            h[i % HASH_BITS] = h[i % HASH_BITS] ^ addr[i];
        end
        return h;
    endfunction

endpackage

// File: rtl/cci_mpf_shim_wro_tag_alloc.sv
// Write tag allocator: free bitmap with lowest-free priority encode plus
// per-tag metadata storage (written on alloc, read by tag on free).
// Ports:
//   clk, reset_n        clock, async active-low reset (all tags free)
//   alloc_en/alloc_meta take alloc_tag this cycle and store its metadata
//   alloc_tag           lowest free tag (valid when not_empty)
//   not_empty           at least one tag free
//   free_en/free_tag    release a tag (ignored if it is not allocated)
//   free_busy           free_tag is currently allocated
//   free_meta           metadata stored for free_tag
module cci_mpf_shim_wro_tag_alloc
    import cci_mpf_shim_wro_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    input  logic          alloc_en,
    input  t_wro_tag_meta alloc_meta,
    output t_wro_tag      alloc_tag,
    output logic          not_empty,
    input  logic          free_en,
    input  t_wro_tag      free_tag,
    output logic          free_busy,
    output t_wro_tag_meta free_meta
);

    logic [N_WR_TAGS-1:0] free_q;
    t_wro_tag_meta        meta_mem [N_WR_TAGS];

    // Scan downward so the last hit, i.e. the lowest free index, wins.
    always_comb begin
        alloc_tag = '0;
        for (int i = N_WR_TAGS - 1; i >= 0; i--) begin
            if (free_q[i]) alloc_tag = t_wro_tag'(i);
        end
    end

    assign not_empty = |free_q;
    assign free_busy = !free_q[free_tag];
    assign free_meta = meta_mem[free_tag];

    // Allocation looks only at the registered bitmap, so a tag released this
    // cycle becomes allocatable on the next one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            free_q <= '1;
        end else begin
            if (alloc_en)              free_q[alloc_tag] <= 1'b0;
            if (free_en && free_busy)  free_q[free_tag]  <= 1'b1;
        end
    end

    // Metadata storage has no reset; entries are only read for busy tags.
    always_ff @(posedge clk) begin
        if (alloc_en) meta_mem[alloc_tag] <= alloc_meta;
    end

endmodule

// File: rtl/cci_mpf_shim_wr_rd_order.sv
// Read-after-write ordering shim between the lockstep AFU buffer head and QLP.
// A read is held at the buffer head while any write hashing to the same
// bucket is unacknowledged. Writes carry a tag in the low mdata bits; the
// original bits are restored on the write response. Requests reach QLP one
// cycle after they are dequeued; both channels always move together.
// Ports:
//   clk, reset_n             clock, async active-low reset
//   afu_c0tx_*               buffer head read request
//   afu_c1tx_*               buffer head write / interrupt request
//   deq_tx                   pop both buffer channels (combinational)
//   afu_c0rx_*, afu_c1rx_*   responses toward the AFU (c1 mdata restored)
//   afu_reset_n              reset forwarded from QLP
//   qlp_c0tx_*, qlp_c1tx_*   registered requests toward QLP
//   qlp_c0tx_alm_full, qlp_c1tx_alm_full  QLP back-pressure
//   qlp_c0rx_*, qlp_c1rx_*   responses from QLP
//   qlp_reset_n              QLP reset
//   err_tag                  sticky: write response carried an unallocated tag
module cci_mpf_shim_wr_rd_order
    import cci_mpf_shim_wro_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,

    input  logic       afu_c0tx_rd_valid,
    input  t_wro_addr  afu_c0tx_addr,
    input  t_wro_mdata afu_c0tx_mdata,
    input  logic       afu_c1tx_wr_valid,
    input  logic       afu_c1tx_intr_valid,
    input  t_wro_addr  afu_c1tx_addr,
    input  t_wro_data  afu_c1tx_data,
    input  t_wro_mdata afu_c1tx_mdata,
    output logic       deq_tx,

    output logic       afu_c0rx_valid,
    output t_wro_data  afu_c0rx_data,
    output t_wro_mdata afu_c0rx_mdata,
    output logic       afu_c1rx_wr_valid,
    output t_wro_mdata afu_c1rx_mdata,
    output logic       afu_reset_n,

    output logic       qlp_c0tx_rd_valid,
    output t_wro_addr  qlp_c0tx_addr,
    output t_wro_mdata qlp_c0tx_mdata,
    output logic       qlp_c1tx_wr_valid,
    output logic       qlp_c1tx_intr_valid,
    output t_wro_addr  qlp_c1tx_addr,
    output t_wro_data  qlp_c1tx_data,
    output t_wro_mdata qlp_c1tx_mdata,
    input  logic       qlp_c0tx_alm_full,
    input  logic       qlp_c1tx_alm_full,

    input  logic       qlp_c0rx_valid,
    input  t_wro_data  qlp_c0rx_data,
    input  t_wro_mdata qlp_c0rx_mdata,
    input  logic       qlp_c1rx_wr_valid,
    input  t_wro_mdata qlp_c1rx_mdata,
    input  logic       qlp_reset_n,

    output logic       err_tag
);

    t_wro_hash     rd_hash;
    t_wro_hash     wr_hash;
    logic          head_valid;
    logic          rd_block;
    logic          wr_block;
    logic          issue;
    logic          alloc_en;
    logic          tag_avail;
    t_wro_tag      alloc_tag;
    t_wro_tag_meta alloc_meta;
    t_wro_tag      rsp_tag;
    logic          rsp_busy;
    logic          rsp_ok;
    t_wro_tag_meta rsp_meta;
    logic          same_bucket;
    t_wro_ctr      ctr [N_BUCKETS];

    assign rd_hash    = wro_hash(afu_c0tx_addr);
    assign wr_hash    = wro_hash(afu_c1tx_addr);
    assign head_valid = afu_c0tx_rd_valid | afu_c1tx_wr_valid | afu_c1tx_intr_valid;

    // Counters are checked before this cycle's write is counted, so a read
    // and write to one bucket at the head issue together (read is older).
    assign rd_block = afu_c0tx_rd_valid && (ctr[rd_hash] != '0);
    assign wr_block = afu_c1tx_wr_valid && (!tag_avail || ctr[wr_hash] == WRO_CTR_MAX);
    assign issue    = head_valid && !qlp_c0tx_alm_full && !qlp_c1tx_alm_full
                      && !rd_block && !wr_block;
    assign deq_tx   = issue;
    assign alloc_en = issue && afu_c1tx_wr_valid;

    assign alloc_meta = {afu_c1tx_mdata[TAG_BITS-1:0], wr_hash};
    assign rsp_tag    = qlp_c1rx_mdata[TAG_BITS-1:0];
    assign rsp_ok     = qlp_c1rx_wr_valid && rsp_busy;

    cci_mpf_shim_wro_tag_alloc u_tag_alloc (
        .clk        (clk),
        .reset_n    (reset_n),
        .alloc_en   (alloc_en),
        .alloc_meta (alloc_meta),
        .alloc_tag  (alloc_tag),
        .not_empty  (tag_avail),
        .free_en    (qlp_c1rx_wr_valid),
        .free_tag   (rsp_tag),
        .free_busy  (rsp_busy),
        .free_meta  (rsp_meta)
    );

    // Responses: c0 is a straight pass-through; c1 gets its tag bits
    // replaced with the original mdata unless the tag was not in flight.
    assign afu_c0rx_valid    = qlp_c0rx_valid;
    assign afu_c0rx_data     = qlp_c0rx_data;
    assign afu_c0rx_mdata    = qlp_c0rx_mdata;
    assign afu_c1rx_wr_valid = qlp_c1rx_wr_valid;
    assign afu_c1rx_mdata    = rsp_ok ? {qlp_c1rx_mdata[MDATA_BITS-1:TAG_BITS], rsp_meta.orig_mdata}
                                      : qlp_c1rx_mdata;
    assign afu_reset_n       = qlp_reset_n;

    // Outstanding-write counters: one increment and one decrement port; a
    // matching inc/dec pair in the same bucket cancels out.
    assign same_bucket = alloc_en && rsp_ok && (rsp_meta.hash == wr_hash);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_BUCKETS; i++) ctr[i] <= '0;
        end else begin
            if (alloc_en && !same_bucket) ctr[wr_hash]       <= ctr[wr_hash] + 1'b1;
            if (rsp_ok && !same_bucket)   ctr[rsp_meta.hash] <= ctr[rsp_meta.hash] - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_tag <= 1'b0;
        end else if (qlp_c1rx_wr_valid && !rsp_busy) begin
            err_tag <= 1'b1;
        end
    end

    // Registered request stage toward QLP; valids drop on idle cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            qlp_c0tx_rd_valid   <= 1'b0;
            qlp_c1tx_wr_valid   <= 1'b0;
            qlp_c1tx_intr_valid <= 1'b0;
            qlp_c0tx_addr       <= '0;
            qlp_c0tx_mdata      <= '0;
            qlp_c1tx_addr       <= '0;
            qlp_c1tx_data       <= '0;
            qlp_c1tx_mdata      <= '0;
        end else begin
            qlp_c0tx_rd_valid   <= issue && afu_c0tx_rd_valid;
            qlp_c1tx_wr_valid   <= issue && afu_c1tx_wr_valid;
            qlp_c1tx_intr_valid <= issue && afu_c1tx_intr_valid;
            if (issue) begin
                qlp_c0tx_addr  <= afu_c0tx_addr;
                qlp_c0tx_mdata <= afu_c0tx_mdata;
                qlp_c1tx_addr  <= afu_c1tx_addr;
                qlp_c1tx_data  <= afu_c1tx_data;
                qlp_c1tx_mdata <= afu_c1tx_wr_valid
                                  ? {afu_c1tx_mdata[MDATA_BITS-1:TAG_BITS], alloc_tag}
                                  : afu_c1tx_mdata;
            end
        end
    end

endmodule

// File: tb/tb_cci_mpf_shim_wr_rd_order.sv
module tb_cci_mpf_shim_wr_rd_order;
    import cci_mpf_shim_wro_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       h_rd, h_wr, h_intr;
    t_wro_addr  h_rd_addr, h_wr_addr;
    t_wro_mdata h_rd_mdata, h_wr_mdata;
    t_wro_data  h_data;
    logic       alm0, alm1;
    logic       c0rx_v;
    t_wro_data  c0rx_data;
    t_wro_mdata c0rx_mdata;
    logic       rsp_v;
    t_wro_mdata rsp_mdata;
    logic       qrst_n;

    logic       deq_tx, err_tag, afu_reset_n;
    logic       afu_c0rx_valid, afu_c1rx_wr_valid;
    t_wro_data  afu_c0rx_data;
    t_wro_mdata afu_c0rx_mdata, afu_c1rx_mdata;
    logic       q_rd_v, q_wr_v, q_intr_v;
    t_wro_addr  q_rd_addr, q_wr_addr;
    t_wro_mdata q_rd_mdata, q_wr_mdata;
    t_wro_data  q_wr_data;

    int total = 0;
    int bad   = 0;

    // Reference state: which tags are in flight, their original mdata bits and bucket.
    bit         m_busy [N_WR_TAGS];
    logic [4:0] m_orig [N_WR_TAGS];
    int         m_hash [N_WR_TAGS];
    bit         m_err;
    bit         deq_seen, err_seen;
    t_wro_mdata rx_seen;

    cci_mpf_shim_wr_rd_order dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .afu_c0tx_rd_valid   (h_rd),
        .afu_c0tx_addr       (h_rd_addr),
        .afu_c0tx_mdata      (h_rd_mdata),
        .afu_c1tx_wr_valid   (h_wr),
        .afu_c1tx_intr_valid (h_intr),
        .afu_c1tx_addr       (h_wr_addr),
        .afu_c1tx_data       (h_data),
        .afu_c1tx_mdata      (h_wr_mdata),
        .deq_tx              (deq_tx),
        .afu_c0rx_valid      (afu_c0rx_valid),
        .afu_c0rx_data       (afu_c0rx_data),
        .afu_c0rx_mdata      (afu_c0rx_mdata),
        .afu_c1rx_wr_valid   (afu_c1rx_wr_valid),
        .afu_c1rx_mdata      (afu_c1rx_mdata),
        .afu_reset_n         (afu_reset_n),
        .qlp_c0tx_rd_valid   (q_rd_v),
        .qlp_c0tx_addr       (q_rd_addr),
        .qlp_c0tx_mdata      (q_rd_mdata),
        .qlp_c1tx_wr_valid   (q_wr_v),
        .qlp_c1tx_intr_valid (q_intr_v),
        .qlp_c1tx_addr       (q_wr_addr),
        .qlp_c1tx_data       (q_wr_data),
        .qlp_c1tx_mdata      (q_wr_mdata),
        .qlp_c0tx_alm_full   (alm0),
        .qlp_c1tx_alm_full   (alm1),
        .qlp_c0rx_valid      (c0rx_v),
        .qlp_c0rx_data       (c0rx_data),
        .qlp_c0rx_mdata      (c0rx_mdata),
        .qlp_c1rx_wr_valid   (rsp_v),
        .qlp_c1rx_mdata      (rsp_mdata),
        .qlp_reset_n         (qrst_n),
        .err_tag             (err_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Hash by repeated 6-bit chunk XOR.
    function automatic int ref_hash(input logic [31:0] a);
        logic [31:0] x;
        int h;
        x = a;
        h = 0;
        while (x != 0) begin
            h = h ^ int'(x & 32'd63);
            x = x >> 6;
        end
        return h;
    endfunction

    function automatic int bucket_count(input int h);
        int n;
        n = 0;
        for (int i = 0; i < N_WR_TAGS; i++) if (m_busy[i] && m_hash[i] == h) n++;
        return n;
    endfunction

    function automatic int lowest_free();
        for (int i = 0; i < N_WR_TAGS; i++) if (!m_busy[i]) return i;
        return -1;
    endfunction

    function automatic bit model_issue();
        bit any;
        any = h_rd | h_wr | h_intr;
        if (!any || alm0 || alm1) return 0;
        if (h_rd && bucket_count(ref_hash(h_rd_addr)) != 0) return 0;
        if (h_wr && (lowest_free() < 0 || bucket_count(ref_hash(h_wr_addr)) >= 15)) return 0;
        return 1;
    endfunction

    task automatic set_idle();
        h_rd = 0; h_wr = 0; h_intr = 0; alm0 = 0; alm1 = 0; rsp_v = 0; c0rx_v = 0;
        h_rd_addr = '0; h_wr_addr = '0; h_rd_mdata = '0; h_wr_mdata = '0; h_data = '0;
        rsp_mdata = '0; c0rx_data = '0; c0rx_mdata = '0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < N_WR_TAGS; i++) m_busy[i] = 0;
        m_err = 0;
    endtask

    task automatic do_reset();
        set_idle();
        #2 reset_n = 0;
        clear_model();
        @(negedge clk);
        chk("reset_valids", 128'({q_rd_v, q_wr_v, q_intr_v}), 128'(3'b000));
        chk("reset_deq_err", 128'({deq_tx, err_tag}), 128'(2'b00));
        reset_n = 1;
        @(posedge clk); #1;
    endtask

    // One clock: comb checks mid-cycle, model update, then registered checks.
    task automatic step();
        bit iss, e_rd, e_wr, e_intr;
        int et, t;
        t_wro_mdata exp_rx, e_wr_mdata;
        @(negedge clk);
        iss = model_issue();
        deq_seen = deq_tx;
        err_seen = err_tag;
        rx_seen  = afu_c1rx_mdata;
        chk("deq_tx", 128'(deq_tx), 128'(iss));
        chk("err_tag", 128'(err_tag), 128'(m_err));
        chk("c0rx_pass", {44'd0, afu_c0rx_valid, afu_c0rx_mdata, afu_c0rx_data},
                         {44'd0, c0rx_v, c0rx_mdata, c0rx_data});
        t = int'(rsp_mdata[4:0]);
        if (rsp_v) begin
            exp_rx = m_busy[t] ? {rsp_mdata[15:5], m_orig[t]} : rsp_mdata;
            chk("c1rx_mdata", 128'({afu_c1rx_wr_valid, afu_c1rx_mdata}), 128'({1'b1, exp_rx}));
        end else begin
            chk("c1rx_valid", 128'(afu_c1rx_wr_valid), 128'(1'b0));
        end
        e_rd = iss & h_rd; e_wr = iss & h_wr; e_intr = iss & h_intr;
        et = lowest_free();
        e_wr_mdata = {h_wr_mdata[15:5], et[4:0]};
        if (rsp_v) begin
            if (m_busy[t]) m_busy[t] = 0;
            else m_err = 1;
        end
        if (e_wr) begin
            m_busy[et] = 1;
            m_orig[et] = h_wr_mdata[4:0];
            m_hash[et] = ref_hash(h_wr_addr);
        end
        @(posedge clk); #1;
        chk("qlp_valids", 128'({q_rd_v, q_wr_v, q_intr_v}), 128'({e_rd, e_wr, e_intr}));
        if (e_rd) chk("qlp_rd", 128'({q_rd_addr, q_rd_mdata}), 128'({h_rd_addr, h_rd_mdata}));
        if (e_wr || e_intr) chk("qlp_wr", 128'({q_wr_addr, q_wr_data}), 128'({h_wr_addr, h_data}));
        if (e_wr)   chk("qlp_wr_tag", 128'(q_wr_mdata), 128'(e_wr_mdata));
        if (e_intr) chk("qlp_intr_mdata", 128'(q_wr_mdata), 128'(h_wr_mdata));
    endtask

    typedef struct {
        bit rd; int ra; bit wr; int wa; bit a0; bit a1;
        bit rsp; int tag; bit exp_deq; bit exp_err; int exp_rx;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mkrow(bit rd, int ra, bit wr, int wa, bit a0, bit a1,
                                   bit rsp, int tag, bit ed, bit ee, int erx);
        vec_t v;
        v.rd = rd; v.ra = ra; v.wr = wr; v.wa = wa; v.a0 = a0; v.a1 = a1;
        v.rsp = rsp; v.tag = tag; v.exp_deq = ed; v.exp_err = ee; v.exp_rx = erx;
        return v;
    endfunction

    function automatic t_wro_addr rand_addr();
        return t_wro_addr'($urandom_range(0, 7)) | (t_wro_addr'($urandom_range(0, 3)) << 8);
    endfunction

    task automatic new_head();
        int k;
        k = $urandom_range(0, 5);
        h_rd   = (k == 1 || k == 3 || k == 5);
        h_wr   = (k == 2 || k == 3);
        h_intr = (k == 4);
        h_rd_addr  = rand_addr();
        h_wr_addr  = rand_addr();
        h_rd_mdata = t_wro_mdata'($urandom);
        h_wr_mdata = t_wro_mdata'($urandom);
        h_data     = {$urandom, $urandom};
    endtask

    initial begin
        int busy_q[$];
        int t;
        qrst_n = 1;
        set_idle();
        do_reset();
        chk("afu_reset_fwd", 128'(afu_reset_n), 128'(1'b1));

        // rd/wr addr 5 -> bucket 5, addr 9 -> bucket 9; write mdata 0x1234.
        tbl.push_back(mkrow(0,0, 0,0, 0,0, 0,0, 0,0, -1));
        tbl.push_back(mkrow(0,0, 1,5, 0,0, 0,0, 1,0, -1));
        tbl.push_back(mkrow(1,5, 0,0, 0,0, 0,0, 0,0, -1));
        tbl.push_back(mkrow(1,5, 0,0, 0,0, 1,0, 0,0, 'h1234));
        tbl.push_back(mkrow(1,5, 0,0, 0,0, 0,0, 1,0, -1));
        tbl.push_back(mkrow(0,0, 1,5, 0,0, 0,0, 1,0, -1));
        tbl.push_back(mkrow(1,9, 0,0, 0,0, 0,0, 1,0, -1));
        tbl.push_back(mkrow(0,0, 0,0, 0,0, 1,0, 0,0, 'h1234));
        tbl.push_back(mkrow(1,5, 1,5, 0,0, 0,0, 1,0, -1));
        tbl.push_back(mkrow(1,5, 0,0, 0,0, 0,0, 0,0, -1));
        tbl.push_back(mkrow(1,5, 0,0, 0,0, 1,0, 0,0, 'h1234));
        tbl.push_back(mkrow(1,5, 0,0, 0,0, 0,0, 1,0, -1));
        tbl.push_back(mkrow(1,9, 0,0, 1,0, 0,0, 0,0, -1));
        tbl.push_back(mkrow(1,9, 0,0, 0,0, 0,0, 1,0, -1));
        tbl.push_back(mkrow(1,9, 0,0, 0,1, 0,0, 0,0, -1));
        tbl.push_back(mkrow(0,0, 0,0, 0,0, 1,7, 0,0, 'h1227));
        tbl.push_back(mkrow(0,0, 0,0, 0,0, 0,0, 0,1, -1));

        foreach (tbl[r]) begin
            h_rd = tbl[r].rd; h_rd_addr = t_wro_addr'(tbl[r].ra); h_rd_mdata = 16'h00a5;
            h_wr = tbl[r].wr; h_wr_addr = t_wro_addr'(tbl[r].wa); h_wr_mdata = 16'h1234;
            h_intr = 0; h_data = 64'hdead_beef_0000_0000 | 64'(r);
            alm0 = tbl[r].a0; alm1 = tbl[r].a1;
            rsp_v = tbl[r].rsp; rsp_mdata = {11'(16'h1234 >> 5), 5'(tbl[r].tag)};
            step();
            chk($sformatf("tbl%0d_deq", r), 128'(deq_seen), 128'(tbl[r].exp_deq));
            chk($sformatf("tbl%0d_err", r), 128'(err_seen), 128'(tbl[r].exp_err));
            if (tbl[r].exp_rx >= 0)
                chk($sformatf("tbl%0d_rx", r), 128'(rx_seen), 128'(tbl[r].exp_rx));
        end

        // All 32 tags in flight: 33rd write waits until a response frees tag 13.
        do_reset();
        for (int i = 0; i < 32; i++) begin
            h_wr = 1; h_wr_addr = t_wro_addr'(i); h_wr_mdata = t_wro_mdata'($urandom);
            step();
            chk("t4_fill", 128'(deq_seen), 128'(1'b1));
        end
        h_wr_addr = 40;
        step(); chk("t4_full", 128'(deq_seen), 128'(1'b0));
        step(); chk("t4_full", 128'(deq_seen), 128'(1'b0));
        rsp_v = 1; rsp_mdata = {11'h3a1, 5'd13};
        step(); chk("t4_free_cycle", 128'(deq_seen), 128'(1'b0));
        rsp_v = 0;
        step(); chk("t4_issue", 128'(deq_seen), 128'(1'b1));
        chk("t4_tag", 128'(q_wr_mdata[4:0]), 128'(5'd13));

        // Bucket counter saturation: 15 writes to bucket 3, the 16th waits.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            h_wr = 1; h_wr_addr = 3; h_wr_mdata = t_wro_mdata'($urandom);
            step();
        end
        step(); chk("ctr_max_stall", 128'(deq_seen), 128'(1'b0));
        rsp_v = 1; rsp_mdata = {11'h0f0, 5'd4};
        step(); chk("ctr_max_stall", 128'(deq_seen), 128'(1'b0));
        rsp_v = 0;
        step(); chk("ctr_max_issue", 128'(deq_seen), 128'(1'b1));
        chk("ctr_max_tag", 128'(q_wr_mdata[4:0]), 128'(5'd4));

        // Random traffic against the reference model.
        do_reset();
        new_head();
        for (int c = 0; c < 3000; c++) begin
            alm0 = ($urandom_range(0, 9) == 0);
            alm1 = ($urandom_range(0, 9) == 0);
            c0rx_v = $urandom_range(0, 1) != 0;
            c0rx_data = {$urandom, $urandom};
            c0rx_mdata = t_wro_mdata'($urandom);
            rsp_v = 0;
            busy_q.delete();
            for (int i = 0; i < N_WR_TAGS; i++) if (m_busy[i]) busy_q.push_back(i);
            if (busy_q.size() > 0 && $urandom_range(0, 2) == 0) begin
                t = busy_q[$urandom_range(0, busy_q.size() - 1)];
                rsp_v = 1;
                rsp_mdata = {11'($urandom), 5'(t)};
            end else if ($urandom_range(0, 199) == 0 && lowest_free() >= 0) begin
                rsp_v = 1;
                rsp_mdata = {11'($urandom), 5'(lowest_free())};
            end
            step();
            if (deq_seen || !(h_rd | h_wr | h_intr)) new_head();
        end

        // Reset with a write in flight: its late response is an unknown tag.
        do_reset();
        h_wr = 1; h_wr_addr = 12; h_wr_mdata = 16'hbeef;
        step();
        chk("late_issue", 128'(deq_seen), 128'(1'b1));
        do_reset();
        rsp_v = 1; rsp_mdata = {11'(16'hbeef >> 5), 5'd0};
        step();
        chk("late_rx_pass", 128'(rx_seen), 128'({11'(16'hbeef >> 5), 5'd0}));
        rsp_v = 0;
        step();
        chk("late_err", 128'(err_seen), 128'(1'b1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
